// File: rtl/rd_resp_buffer_if.sv
// rtl/rd_resp_buffer_if.sv - read-response buffer bus; stat signals exist only with RD_RESP_BUF_STATS_EN
interface rd_resp_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              rd_issue;
    logic              rd_credit_ok;
    logic              master_readdatavalid;
    logic [DATA_W-1:0] master_readdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  level;
    logic [CNT_W-1:0]  outstanding;
    logic              overflow;
`ifdef RD_RESP_BUF_STATS_EN
    logic [15:0]       stat_words;
    logic [7:0]        stat_drops;
`endif

    modport master (
        output flush, rd_issue, master_readdatavalid, master_readdata, out_ready,
        input  rd_credit_ok, out_valid, out_data, level, outstanding, overflow
`ifdef RD_RESP_BUF_STATS_EN
        , input stat_words, stat_drops
`endif
    );

    modport slave (
        input  flush, rd_issue, master_readdatavalid, master_readdata, out_ready,
        output rd_credit_ok, out_valid, out_data, level, outstanding, overflow
`ifdef RD_RESP_BUF_STATS_EN
        , output stat_words, stat_drops
`endif
    );
endinterface

// File: rtl/rd_resp_buffer.sv
// rtl/rd_resp_buffer.sv - credit-gated FWFT buffer for Avalon-MM read responses
// Optional pop/drop statistics counters are enabled by defining RD_RESP_BUF_STATS_EN.
module rd_resp_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    rd_resp_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_level;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;
    logic              r_overflow;

    logic [CNT_W:0]    w_reserved;
    logic              w_credit_ok;
    logic              w_resp;
    logic              w_orphan;
    logic              w_discard;
    logic              w_push_try;
    logic              w_full_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_issue_err;
    logic [CNT_W-1:0]  w_outstanding_nxt;

    // Credit counts both stored words and words still in flight, so a granted
    // read always has a slot waiting for its response.
    assign w_reserved  = {1'b0, r_level} + {1'b0, r_outstanding};
    assign w_credit_ok = (w_reserved < (CNT_W + 1)'(DEPTH));

    assign w_resp      = bus.master_readdatavalid && (r_outstanding != '0);
    assign w_orphan    = bus.master_readdatavalid && (r_outstanding == '0);
    assign w_discard   = w_resp && (r_discard != '0);
    assign w_push_try  = w_resp && (r_discard == '0);
    assign w_pop       = (r_level != '0) && bus.out_ready;
    assign w_full_drop = w_push_try && (r_level == DEPTH_C) && !w_pop;
    assign w_push      = w_push_try && !w_full_drop;
    assign w_issue_err = bus.rd_issue && !w_credit_ok;

    assign w_outstanding_nxt = r_outstanding + CNT_W'(bus.rd_issue) - CNT_W'(w_resp);

    // Flush wins over push in its cycle; the word in flight is covered by discard.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.master_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (bus.flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_discard  <= w_outstanding_nxt;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_level <= r_level + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_discard) begin
                    r_discard <= r_discard - CNT_W'(1);
                end
                if (w_issue_err || w_orphan || w_full_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_credit_ok = w_credit_ok;
    assign bus.out_valid    = (r_level != '0);
    // Gated so the unreset memory never shows X on the output.
    assign bus.out_data     = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.level        = r_level;
    assign bus.outstanding  = r_outstanding;
    assign bus.overflow     = r_overflow;

`ifdef RD_RESP_BUF_STATS_EN
    logic [15:0] r_stat_words;
    logic [7:0]  r_stat_drops;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_words <= '0;
            r_stat_drops <= '0;
        end else begin
            if (bus.flush) begin
                r_stat_words <= '0;
            end else if (w_pop && (r_stat_words != 16'hFFFF)) begin
                r_stat_words <= r_stat_words + 16'd1;
            end
            // Only overflow losses count; words discarded after a flush are expected.
            if (!bus.flush && (w_orphan || w_full_drop) && (r_stat_drops != 8'hFF)) begin
                r_stat_drops <= r_stat_drops + 8'd1;
            end
        end
    end

    assign bus.stat_words = r_stat_words;
    assign bus.stat_drops = r_stat_drops;
`endif
endmodule

// File: tb/tb_rd_resp_buffer.sv
// tb/tb_rd_resp_buffer.sv - scoreboard bench for rd_resp_buffer (stat checks with RD_RESP_BUF_STATS_EN)
`timescale 1ns/1ps
module tb_rd_resp_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rd_resp_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    rd_resp_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb_q[$];
    int pop_model  = 0;
    int drop_model = 0;

    // One clock: scoreboard pop at negedge, then clear single-cycle pulses after the edge.
    task automatic cycle();
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready && !bus.flush) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_pop: got %h, expected no word", bus.out_data);
            end else begin
                exp = sb_q.pop_front();
                if (bus.out_data !== exp) begin
                    n_err++;
                    $display("FAIL sb_order: got %h expected %h", bus.out_data, exp);
                end
            end
            pop_model++;
        end
        if (bus.flush) pop_model = 0;
        @(posedge clk);
        #1;
        bus.rd_issue = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_issue = 1'b1;
            cycle();
        end
    endtask

    task automatic resp(input logic [DATA_W-1:0] v, input bit store, input bit also_issue);
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = v;
        bus.rd_issue = also_issue;
        if (store) sb_q.push_back(v);
        cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.level !== 0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        n_cmp++; if (bus.outstanding !== 0) begin n_err++; $display("FAIL reset_outstanding: got %0d expected 0", bus.outstanding); end
        n_cmp++; if (bus.rd_credit_ok !== 1'b1) begin n_err++; $display("FAIL reset_credit: got %b expected 1", bus.rd_credit_ok); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        n_cmp++; if ($isunknown(bus.out_data)) begin n_err++; $display("FAIL reset_out_data_x: got %h expected known", bus.out_data); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b0;
        issue(4);
        n_cmp++; if (bus.outstanding !== 4) begin n_err++; $display("FAIL basic_outstanding4: got %0d expected 4", bus.outstanding); end
        resp(32'hA0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0) begin n_err++; $display("FAIL basic_fwft: got %b/%h expected 1/a0", bus.out_valid, bus.out_data); end
        for (int i = 1; i < 4; i++) resp(32'hA0 + i, 1'b1, 1'b0);
        n_cmp++; if (bus.level !== 4) begin n_err++; $display("FAIL basic_level4: got %0d expected 4", bus.level); end
        n_cmp++; if (bus.outstanding !== 0) begin n_err++; $display("FAIL basic_outstanding0: got %0d expected 0", bus.outstanding); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.level !== 4 - i) begin n_err++; $display("FAIL basic_drain_%0d: got %b/%0d expected 1/%0d", i, bus.out_valid, bus.level, 4 - i); end
            cycle();
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || sb_q.size() != 0) begin n_err++; $display("FAIL basic_empty: got %b/%0d expected 0/0", bus.out_valid, sb_q.size()); end
    endtask

    task automatic test_credit_wrap();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue(1);
            if (i == 14) begin
                n_cmp++; if (bus.rd_credit_ok !== 1'b1) begin n_err++; $display("FAIL credit_at15: got %b expected 1", bus.rd_credit_ok); end
            end
        end
        n_cmp++; if (bus.rd_credit_ok !== 1'b0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL credit_at16: got %b/%b expected 0/0", bus.rd_credit_ok, bus.overflow); end
        issue(1);
        n_cmp++; if (bus.overflow !== 1'b1 || bus.outstanding !== 17) begin n_err++; $display("FAIL credit_17th: got %b/%0d expected 1/17", bus.overflow, bus.outstanding); end
        for (int v = 0; v < 16; v++) resp(DATA_W'(v), 1'b1, 1'b0);
        n_cmp++; if (bus.level !== 16 || bus.outstanding !== 1 || bus.rd_credit_ok !== 1'b0) begin n_err++; $display("FAIL credit_full: got %0d/%0d/%b expected 16/1/0", bus.level, bus.outstanding, bus.rd_credit_ok); end
        bus.out_ready = 1'b1;
        resp(DATA_W'(16), 1'b1, 1'b0);
        n_cmp++; if (bus.level !== 16 || bus.outstanding !== 0) begin n_err++; $display("FAIL wrap_push_pop_full: got %0d/%0d expected 16/0", bus.level, bus.outstanding); end
        n_cmp++; if (bus.rd_credit_ok !== 1'b0) begin n_err++; $display("FAIL wrap_credit_until_pop: got %b expected 0", bus.rd_credit_ok); end
        cycle();
        n_cmp++; if (bus.rd_credit_ok !== 1'b1 || bus.level !== 15) begin n_err++; $display("FAIL wrap_credit_after_pop: got %b/%0d expected 1/15", bus.rd_credit_ok, bus.level); end
        issue(1);
        resp(DATA_W'(17), 1'b1, 1'b1);
        resp(DATA_W'(18), 1'b1, 1'b1);
        resp(DATA_W'(19), 1'b1, 1'b0);
        for (int t = 0; t < 40 && sb_q.size() != 0; t++) cycle();
        n_cmp++; if (sb_q.size() != 0 || bus.level !== 0 || bus.outstanding !== 0) begin n_err++; $display("FAIL wrap_drain: got %0d left/%0d/%0d expected 0/0/0", sb_q.size(), bus.level, bus.outstanding); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        issue(3);
        bus.flush = 1'b1;
        cycle();
        n_cmp++; if (bus.overflow !== 1'b0 || bus.level !== 0) begin n_err++; $display("FAIL flush_clear: got %b/%0d expected 0/0", bus.overflow, bus.level); end
        n_cmp++; if (bus.outstanding !== 3 || bus.rd_credit_ok !== 1'b1) begin n_err++; $display("FAIL flush_outstanding: got %0d/%b expected 3/1", bus.outstanding, bus.rd_credit_ok); end
        for (int i = 0; i < 3; i++) begin
            resp(32'hB0 + i, 1'b0, 1'b0);
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.level !== 0) begin n_err++; $display("FAIL flush_discard_%0d: got %b/%0d expected 0/0", i, bus.out_valid, bus.level); end
        end
        n_cmp++; if (bus.outstanding !== 0) begin n_err++; $display("FAIL flush_outstanding0: got %0d expected 0", bus.outstanding); end
        issue(1);
        resp(32'hC0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC0) begin n_err++; $display("FAIL flush_c0: got %b/%h expected 1/c0", bus.out_valid, bus.out_data); end
        cycle();
        n_cmp++; if (sb_q.size() != 0 || bus.level !== 0 || bus.outstanding !== 0) begin n_err++; $display("FAIL flush_end: got %0d left/%0d/%0d expected 0/0/0", sb_q.size(), bus.level, bus.outstanding); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_orphan();
        bus.out_ready = 1'b0;
        issue(1);
        resp(32'hD0, 1'b1, 1'b0);
        resp(32'hE0, 1'b0, 1'b0);
        drop_model++;
        n_cmp++; if (bus.overflow !== 1'b1 || bus.level !== 1 || bus.outstanding !== 0) begin n_err++; $display("FAIL orphan: got %b/%0d/%0d expected 1/1/0", bus.overflow, bus.level, bus.outstanding); end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.level !== 0 || sb_q.size() != 0) begin n_err++; $display("FAIL orphan_drain: got %0d/%0d expected 0/0", bus.level, sb_q.size()); end
`ifdef RD_RESP_BUF_STATS_EN
        n_cmp++; if (bus.stat_drops !== 8'(drop_model)) begin n_err++; $display("FAIL stat_drops: got %0d expected %0d", bus.stat_drops, drop_model); end
        n_cmp++; if (bus.stat_words !== 16'(pop_model)) begin n_err++; $display("FAIL stat_words: got %0d expected %0d", bus.stat_words, pop_model); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0;
        bus.rd_issue = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_credit_wrap();
        test_flush();
        test_orphan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rd_resp_buffer.md
Name: rd_resp_buffer

Overview:
Response-side buffer that sits directly downstream of the Avalon-MM read master. It captures master_readdata words qualified by master_readdatavalid into a first-word-fall-through FIFO and presents them to the byte-processing consumer over a valid/ready interface. It tracks reads in flight and grants the master a credit only when buffer space is already reserved for the response. As a result, the slave can never overrun the FIFO.

Parameters:
DATA_W, 32, width of read data word
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of level and outstanding counters (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of buffered data (pulsed at start_byte of a new transfer)
rd_issue  in  1  pulse: read master had a read command accepted this cycle (read & !waitrequest)
rd_credit_ok  out  1  master may issue another read this cycle
master_readdatavalid  in  1  response word valid
master_readdata  in  DATA_W  response word
out_valid  out  1  out_data holds a valid word
out_data  out  DATA_W  head-of-FIFO word
out_ready  in  1  consumer accepts the word
level  out  CNT_W  words currently stored
outstanding  out  CNT_W  reads issued but not yet returned
overflow  out  1  sticky error flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - rd/wr pointers, level, outstanding and discard count go to 0.
  - overflow = 0, out_valid = 0, rd_credit_ok = 1 (after reset is released, combinational on counters).
- Counters:
  - reserved = level + outstanding.
  - rd_credit_ok = (reserved < DEPTH), combinational.
- Issue:
  - rd_issue increments outstanding, even if rd_credit_ok is low.
  - rd_issue while rd_credit_ok = 0 sets overflow.
- Response (master_readdatavalid = 1):
  - outstanding decrements.
  - If discard > 0: the word is dropped and discard decrements.
  - Otherwise the word is written at wr_ptr and level increments.
- Pop: out_valid & out_ready advances rd_ptr and decrements level.
- FWFT: out_valid = (level != 0); out_data = mem[rd_ptr] with zero-cycle latency. A word written in cycle N is visible at out_valid in cycle N+1.
- Simultaneous events:
  - Issue and response in the same cycle: outstanding unchanged.
  - Push and pop in the same cycle: level unchanged. This is legal even when level = DEPTH.
- Error cases (both set overflow):
  - Response with outstanding = 0: word dropped, counters unchanged.
  - Response arriving when level = DEPTH with no simultaneous pop: word dropped, outstanding still decrements.
- Pointers: wrap modulo DEPTH using natural binary rollover of $clog2(DEPTH)-bit pointers.
- Flush (synchronous, highest priority over push/pop in its cycle):
  - level and pointers go to 0.
  - discard is loaded with outstanding (accounting for same-cycle rd_issue and readdatavalid).
  - overflow is cleared.
  - In-flight responses still decrement outstanding; they are discarded while discard > 0.
  - rd_credit_ok is unaffected by the flush itself (reserved still counts outstanding).
- out_data when out_valid = 0: do-not-care, but it must not be X after reset (memory reset not required; gate with out_valid in the bench).

Optional Feature:
RD_RESP_BUF_STATS_EN
- Defined:
  - Adds port stat_words (out, 16): saturating count of words popped (out_valid & out_ready).
  - Reset to 0 by reset_n and by flush; holds at 16'hFFFF.
  - Adds port stat_drops (out, 8): saturating count of responses dropped for overflow. Discard-by-flush drops are not counted.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid 0, level 0, outstanding 0, rd_credit_ok 1, overflow 0.
- 4 rd_issue pulses, then 4 responses 0xA0..0xA3 with out_ready = 0 -> level 4, outstanding 0. Raise out_ready -> words popped 0xA0, 0xA1, 0xA2, 0xA3 in order on consecutive cycles.
- 16 issues with no responses -> rd_credit_ok low after the 16th. A 17th issue -> overflow = 1. 16 responses -> level 16, rd_credit_ok stays 0 until the first pop.
- Level 16 with out_ready = 1 and a response arriving in the same cycle -> level stays 16, no overflow, FIFO order preserved across pointer wrap (values 0..19 through 20 entries).
- 3 issues, flush, then 3 responses 0xB0..0xB2, then 1 issue and response 0xC0 -> only 0xC0 appears at out_data; outstanding returns to 0.
- Response with outstanding = 0 -> overflow = 1, level unchanged. With RD_RESP_BUF_STATS_EN: stat_drops = 1, and stat_words counts exactly the popped words.
